// File: rtl/spram_pkg.sv
// ---------------------------------------------------------------------------
// spram_pkg : arbitration priority encoding and level-width helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spram_pkg;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } pri_e;

  // Level counts 0..DEPTH inclusive, so it needs one bit beyond the address.
  localparam int LVL_EXTRA_W = 1;

  function automatic int lvl_width(input int addr_w);
    return addr_w + LVL_EXTRA_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spram_array.sv
// ---------------------------------------------------------------------------
// spram_array : single-port RAM, synchronous read, no reset
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spram_array #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= data;
    end else begin
      out <= mem_q[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/spram_fifo.sv
// ---------------------------------------------------------------------------
// spram_fifo : FIFO on one single-port RAM plus an output register.
// Optional synchronous flush port when SPRAM_FIFO_FLUSH_EN is defined.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spram_fifo
  import spram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef SPRAM_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   level
);

  localparam int LVL_W = lvl_width(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fetch_q, fetch_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  pri_e              pri_q, pri_d;
  logic              en_q;

  logic              wr_req, fetch_req;
  logic              wr_grant, fetch_grant;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_out;

  always_comb begin
    wr_req      = en_q && wr_valid && (level_q < LVL_W'(DEPTH));
    fetch_req   = (level_q != '0) && !fetch_q && (!out_valid_q || rd_ready);
    wr_grant    = wr_req && (!fetch_req || (pri_q == PRI_WR));
    fetch_grant = fetch_req && (!wr_req || (pri_q == PRI_RD));

    pri_d = pri_q;
    if (wr_req && fetch_req) begin
      pri_d = fetch_grant ? PRI_WR : PRI_RD;
    end

    wr_ptr_d = wr_grant    ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = fetch_grant ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_grant) begin
      level_d = level_q + LVL_W'(1);
    end else if (fetch_grant) begin
      level_d = level_q - LVL_W'(1);
    end

    fetch_d = fetch_grant;

    // A fetch is only issued when the output register will be free, so the
    // load never collides with a held entry.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fetch_q) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_out;
    end else if (rd_ready) begin
      out_valid_d = 1'b0;
    end

    ram_addr = wr_grant ? wr_ptr_q : rd_ptr_q;
  end

`ifdef SPRAM_FIFO_FLUSH_EN
  assign wr_ready = wr_grant && !flush;
`else
  assign wr_ready = wr_grant;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fetch_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pri_q       <= PRI_RD;
      en_q        <= 1'b0;
    end
`ifdef SPRAM_FIFO_FLUSH_EN
    else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fetch_q     <= 1'b0;
      out_valid_q <= 1'b0;
      en_q        <= 1'b1;
    end
`endif
    else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      fetch_q     <= fetch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pri_q       <= pri_d;
      en_q        <= 1'b1;
    end
  end

  spram_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .we    (wr_ready),
    .addr  (ram_addr),
    .data  (wr_data),
    .out   (ram_out)
  );

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;
  assign level    = level_q;

endmodule

`default_nettype wire

// File: doc/spram_fifo.md
SPRAM_FIFO -- requirements
Module: spram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bit width.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  write data offered.
REQ-006 SHALL have port wr_ready  output  1  write accepted when wr_valid && wr_ready at rising edge.
REQ-007 SHALL have port wr_data  input  WIDTH  write data.
REQ-008 SHALL have port rd_valid  output  1  rd_data holds a valid entry.
REQ-009 SHALL have port rd_ready  input  1  consumer takes rd_data when rd_valid && rd_ready at rising edge.
REQ-010 SHALL have port rd_data  output  WIDTH  oldest entry.
REQ-011 SHALL have port level  output  ADDR_W+1  entries stored in RAM, 0..DEPTH, excluding the output register.

Function
REQ-012 SHALL store entries in one single-port RAM: at most one access per cycle, either a write or a read.
REQ-013 SHALL drive wr_ready = (level < DEPTH) && port granted to write this cycle.
REQ-014 SHALL request a read (fetch) when level > 0, no fetch in flight, and the output register is empty or is being consumed this cycle.
REQ-015 SHALL arbitrate with a one-bit priority toggle when write and fetch both request: the winner takes the port and priority passes to the other side; after reset, priority = read.
REQ-016 SHALL give an uncontested requester the port without changing priority.
REQ-017 SHALL use a synchronous RAM read: fetch address in cycle t, data loaded into the output register at the end of cycle t+1, rd_valid high from cycle t+2.
REQ-018 SHALL hold rd_data and rd_valid stable while rd_valid && !rd_ready.
REQ-019 SHALL advance wr_ptr on write and rd_ptr on fetch; both wrap DEPTH-1 -> 0 with no lost or duplicated entry.
REQ-020 SHALL update level at each edge: +1 on write, -1 on fetch; a write and a fetch never occur in the same cycle.
REQ-021 SHALL preserve strict FIFO order across wrap, arbitration and back-pressure.
REQ-022 SHALL give a minimum latency of 3 rising edges from write acceptance to rd_valid when the block is empty and idle.
REQ-023 SHALL keep wr_ready low at level == DEPTH; the output register adds one extra buffered entry, so the total held is DEPTH+1.

Reset
REQ-024 SHALL, while reset_n is low, immediately force: wr_ptr=0, rd_ptr=0, level=0, fetch-in-flight=0, rd_valid=0, rd_data=0, wr_ready=0, priority=read.
REQ-025 SHALL discard all data and any in-flight fetch on reset asserted mid-operation; RAM contents are don't-care after reset.
REQ-026 SHALL raise wr_ready no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL, with macro SPRAM_FIFO_FLUSH_EN defined, add input port flush (1 bit, synchronous): at the edge flush is high, pointers, level, rd_valid and fetch-in-flight clear; writes and fetches in that cycle are ignored.
REQ-028 SHALL, without SPRAM_FIFO_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-029 SHALL place the arbitration priority encoding (PRI_RD, PRI_WR) and the level-width helper constant in the shared package spram_pkg.
REQ-030 SHALL implement the storage as sub-module spram_array (WIDTH, ADDR_W; ports clock, we, addr, data, out), which has no reset.

Verification
REQ-031 SHALL cover: reset, write 0x11, rd_ready=1 -> rd_valid on the 3rd edge after acceptance with rd_data=0x11, level returns to 0.
REQ-032 SHALL cover: rd_ready=0, write 17 values 0x00..0x10 (ADDR_W=4) -> 16 in RAM plus 1 in the output register, wr_ready=0 at level=16; then drain -> 0x00..0x10 in order.
REQ-033 SHALL cover: continuous wr_valid and rd_ready with ready data -> grants alternate read/write each cycle, output matches input order.
REQ-034 SHALL cover: 40 writes and reads interleaved across pointer wrap -> no loss or duplication, level never exceeds 16.
REQ-035 SHALL cover: reset_n pulsed low mid-fetch with level=5 -> rd_valid=0, level=0 immediately, and the first write after reset returns unchanged.
REQ-036 SHALL cover, with SPRAM_FIFO_FLUSH_EN: flush with level=7 and rd_valid=1 -> next cycle level=0, rd_valid=0, wr_ready=1.
